// File: rtl/alu_iq_param.sv
// Age-ordered collapsing issue queue for one ALU pipeline: entry 0 is oldest,
// oldest ready entry issues combinationally, younger entries shift down behind it.
module alu_iq_param #(
  parameter int IQ_ENTRIES         = 8,
  parameter int DISPATCH_WAYS      = 4,
  parameter int OP_WIDTH           = 4,
  parameter int LOG_PR_COUNT       = 7,
  parameter int LOG_PRF_BANK_COUNT = 2,
  parameter int LOG_ROB_ENTRIES    = 7
) (
  input  logic                                                  CLK,
  input  logic                                                  nRST,
  input  logic [DISPATCH_WAYS-1:0]                              dispatch_valid_by_way,
  input  logic [DISPATCH_WAYS-1:0][OP_WIDTH-1:0]                dispatch_op_by_way,
  input  logic [DISPATCH_WAYS-1:0][31:0]                        dispatch_imm_by_way,
  input  logic [DISPATCH_WAYS-1:0][LOG_PR_COUNT-1:0]            dispatch_A_PR_by_way,
  input  logic [DISPATCH_WAYS-1:0]                              dispatch_A_unneeded_by_way,
  input  logic [DISPATCH_WAYS-1:0]                              dispatch_A_ready_by_way,
  input  logic [DISPATCH_WAYS-1:0][LOG_PR_COUNT-1:0]            dispatch_B_PR_by_way,
  input  logic [DISPATCH_WAYS-1:0]                              dispatch_is_imm_by_way,
  input  logic [DISPATCH_WAYS-1:0]                              dispatch_B_ready_by_way,
  input  logic [DISPATCH_WAYS-1:0][LOG_PR_COUNT-1:0]            dispatch_dest_PR_by_way,
  input  logic [DISPATCH_WAYS-1:0][LOG_ROB_ENTRIES-1:0]         dispatch_ROB_index_by_way,
  output logic [DISPATCH_WAYS-1:0]                              dispatch_ack_by_way,
  input  logic                                                  pipeline_ready,
  input  logic [2**LOG_PRF_BANK_COUNT-1:0]                      WB_bus_valid_by_bank,
  input  logic [2**LOG_PRF_BANK_COUNT-1:0][LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0] WB_bus_upper_PR_by_bank,
  input  logic                                                  flush_valid,
  input  logic [LOG_ROB_ENTRIES-1:0]                            flush_ROB_index,
  input  logic [LOG_ROB_ENTRIES-1:0]                            rob_head_index,
  output logic                                                  issue_valid,
  output logic [OP_WIDTH-1:0]                                   issue_op,
  output logic                                                  issue_is_imm,
  output logic [31:0]                                           issue_imm,
  output logic                                                  issue_A_unneeded,
  output logic                                                  issue_A_forward,
  output logic [LOG_PRF_BANK_COUNT-1:0]                         issue_A_bank,
  output logic                                                  issue_B_forward,
  output logic [LOG_PRF_BANK_COUNT-1:0]                         issue_B_bank,
  output logic [LOG_PR_COUNT-1:0]                               issue_dest_PR,
  output logic [LOG_ROB_ENTRIES-1:0]                            issue_ROB_index,
  output logic                                                  PRF_req_A_valid,
  output logic [LOG_PR_COUNT-1:0]                               PRF_req_A_PR,
  output logic                                                  PRF_req_B_valid,
  output logic [LOG_PR_COUNT-1:0]                               PRF_req_B_PR,
  output logic [$clog2(IQ_ENTRIES+1)-1:0]                       iq_count
);

  localparam int LPR  = LOG_PR_COUNT;
  localparam int LB   = LOG_PRF_BANK_COUNT;
  localparam int LROB = LOG_ROB_ENTRIES;
  localparam int CW   = $clog2(IQ_ENTRIES+1);
  localparam int IW   = $clog2(IQ_ENTRIES);

  typedef struct packed {
    logic                valid;
    logic [OP_WIDTH-1:0] op;
    logic [31:0]         imm;
    logic [LPR-1:0]      a_pr;
    logic                a_unneeded;
    logic                a_ready;
    logic [LPR-1:0]      b_pr;
    logic                is_imm;
    logic                b_ready;
    logic [LPR-1:0]      dest_pr;
    logic [LROB-1:0]     rob;
  } entry_t;

  entry_t                  entry_q [IQ_ENTRIES];
  entry_t                  entry_d [IQ_ENTRIES];
  entry_t                  upd     [IQ_ENTRIES+1];
  logic [CW-1:0]           count_q, count_d;

  logic [IQ_ENTRIES-1:0]   a_fwd, b_fwd, ready;
  logic [DISPATCH_WAYS-1:0] d_a_fwd, d_b_fwd;
  logic                    found, issue_fire;
  logic [IW-1:0]           sel;
  entry_t                  sel_e;
  logic [CW-1:0]           base, free, acked, survivors;
  logic [LROB-1:0]         flush_age, e_age;

  always_comb begin
    for (int unsigned i = 0; i < IQ_ENTRIES; i++) begin
      a_fwd[i] = WB_bus_valid_by_bank[entry_q[i].a_pr[LB-1:0]] &&
                 (WB_bus_upper_PR_by_bank[entry_q[i].a_pr[LB-1:0]] == entry_q[i].a_pr[LPR-1:LB]);
      b_fwd[i] = WB_bus_valid_by_bank[entry_q[i].b_pr[LB-1:0]] &&
                 (WB_bus_upper_PR_by_bank[entry_q[i].b_pr[LB-1:0]] == entry_q[i].b_pr[LPR-1:LB]);
      ready[i] = entry_q[i].valid &
                 (entry_q[i].a_unneeded | entry_q[i].a_ready | a_fwd[i]) &
                 (entry_q[i].is_imm | entry_q[i].b_ready | b_fwd[i]);
    end
    for (int unsigned k = 0; k < DISPATCH_WAYS; k++) begin
      d_a_fwd[k] = WB_bus_valid_by_bank[dispatch_A_PR_by_way[k][LB-1:0]] &&
                   (WB_bus_upper_PR_by_bank[dispatch_A_PR_by_way[k][LB-1:0]] == dispatch_A_PR_by_way[k][LPR-1:LB]);
      d_b_fwd[k] = WB_bus_valid_by_bank[dispatch_B_PR_by_way[k][LB-1:0]] &&
                   (WB_bus_upper_PR_by_bank[dispatch_B_PR_by_way[k][LB-1:0]] == dispatch_B_PR_by_way[k][LPR-1:LB]);
    end
  end

  // Oldest ready entry wins: the first hit while scanning upward from index 0.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int unsigned i = 0; i < IQ_ENTRIES; i++) begin
      if (!found && ready[i]) begin
        found = 1'b1;
        sel   = IW'(i);
      end
    end
    issue_fire = found & pipeline_ready & ~flush_valid;
    sel_e      = entry_q[sel];
  end

  assign issue_valid      = issue_fire;
  assign issue_op         = sel_e.op;
  assign issue_is_imm     = sel_e.is_imm;
  assign issue_imm        = sel_e.imm;
  assign issue_A_unneeded = sel_e.a_unneeded;
  assign issue_A_forward  = a_fwd[sel];
  assign issue_A_bank     = sel_e.a_pr[LB-1:0];
  assign issue_B_forward  = b_fwd[sel];
  assign issue_B_bank     = sel_e.b_pr[LB-1:0];
  assign issue_dest_PR    = sel_e.dest_pr;
  assign issue_ROB_index  = sel_e.rob;
  assign PRF_req_A_valid  = issue_fire & ~sel_e.a_unneeded & ~a_fwd[sel];
  assign PRF_req_A_PR     = sel_e.a_pr;
  assign PRF_req_B_valid  = issue_fire & ~sel_e.is_imm & ~b_fwd[sel];
  assign PRF_req_B_PR     = sel_e.b_pr;
  assign iq_count         = count_q;

  always_comb begin
    for (int unsigned i = 0; i < IQ_ENTRIES; i++) begin
      upd[i]         = entry_q[i];
      upd[i].a_ready = entry_q[i].a_ready | a_fwd[i];
      upd[i].b_ready = entry_q[i].b_ready | b_fwd[i];
    end
    upd[IQ_ENTRIES] = '0;

    base      = count_q - CW'(issue_fire);
    free      = CW'(IQ_ENTRIES) - base;
    flush_age = flush_ROB_index - rob_head_index;
    acked     = '0;
    survivors = '0;
    e_age     = '0;
    count_d   = count_q;

    for (int unsigned k = 0; k < DISPATCH_WAYS; k++) begin
      dispatch_ack_by_way[k] = dispatch_valid_by_way[k] & (CW'(k) < free) & ~flush_valid & nRST;
      acked = acked + CW'(dispatch_ack_by_way[k]);
    end

    for (int unsigned i = 0; i < IQ_ENTRIES; i++) entry_d[i] = '0;

    if (flush_valid) begin
      // Entries are age-ordered, so the kept set is automatically a prefix.
      for (int unsigned i = 0; i < IQ_ENTRIES; i++) begin
        e_age = upd[i].rob - rob_head_index;
        if (upd[i].valid && (e_age < flush_age)) begin
          entry_d[i] = upd[i];
          survivors  = survivors + CW'(1);
        end
      end
      count_d = survivors;
    end else begin
      for (int unsigned i = 0; i < IQ_ENTRIES; i++) begin
        if (issue_fire && (IW'(i) >= sel)) entry_d[i] = upd[i+1];
        else                               entry_d[i] = upd[i];
        for (int unsigned k = 0; k < DISPATCH_WAYS; k++) begin
          if (dispatch_ack_by_way[k] && (int'(base) + int'(k) == int'(i))) begin
            entry_d[i].valid      = 1'b1;
            entry_d[i].op         = dispatch_op_by_way[k];
            entry_d[i].imm        = dispatch_imm_by_way[k];
            entry_d[i].a_pr       = dispatch_A_PR_by_way[k];
            entry_d[i].a_unneeded = dispatch_A_unneeded_by_way[k];
            entry_d[i].a_ready    = dispatch_A_ready_by_way[k] | d_a_fwd[k];
            entry_d[i].b_pr       = dispatch_B_PR_by_way[k];
            entry_d[i].is_imm     = dispatch_is_imm_by_way[k];
            entry_d[i].b_ready    = dispatch_B_ready_by_way[k] | d_b_fwd[k];
            entry_d[i].dest_pr    = dispatch_dest_PR_by_way[k];
            entry_d[i].rob        = dispatch_ROB_index_by_way[k];
          end
        end
      end
      count_d = base + acked;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      count_q <= '0;
      for (int unsigned i = 0; i < IQ_ENTRIES; i++) entry_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int unsigned i = 0; i < IQ_ENTRIES; i++) entry_q[i] <= entry_d[i];
    end
  end

endmodule
